decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode stage; sits directly downstream of the fetch stage and consumes its pc and instruction stream.
- Accepts {pc, insn} over a valid/ready handshake and splits the instruction into register indices, function fields and a sign-extended immediate.
- Presents the decoded bundle in a registered output slot to the execute/register-read stage.
- A one-entry skid buffer keeps `ready_o` registered (no combinational ready path from `ready_i`) and preserves full throughput under backpressure.

Parameters:
- DWIDTH, 32, instruction and immediate width; only 32 is supported.
- AWIDTH, 32, pc width.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- flush_i  input  1  discard all held and in-flight instructions (branch redirect).
- valid_i  input  1  upstream presents pc_i/insn_i.
- ready_o  output  1  stage can accept this cycle.
- pc_i  input  AWIDTH  pc of the presented instruction.
- insn_i  input  DWIDTH  presented instruction word.
- valid_o  output  1  decoded bundle valid.
- ready_i  input  1  downstream accepts the bundle.
- pc_o  output  AWIDTH  pc of the decoded instruction.
- insn_o  output  DWIDTH  raw instruction, passed through.
- opcode_o  output  7  insn[6:0].
- rd_o  output  5  insn[11:7].
- rs1_o  output  5  insn[19:15].
- rs2_o  output  5  insn[24:20].
- funct3_o  output  3  insn[14:12].
- funct7_o  output  7  insn[31:25].
- imm_o  output  DWIDTH  sign-extended immediate.
- illegal_o  output  1  opcode not in the supported set.

Behaviour:
- Reset (rst==0 at posedge):
  - valid_o=0, skid buffer empty, all data outputs 0.
  - ready_o=1, because it is derived from the empty skid buffer.
  - valid_i is ignored while reset is asserted.
- Handshakes:
  - Input accept when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
  - When valid_o=1 and ready_i=0, all output fields hold stable.
- Output register load:
  - Loads when it is empty or its bundle transfers this cycle.
  - Source is the skid entry if that entry is valid, else the input.
  - Loaded value is the decode of that source.
  - Latency: accept at cycle N gives valid_o=1 at cycle N+1.
  - Throughput: 1 instruction per cycle while ready_i=1.
- Skid buffer:
  - Captures the raw {pc, insn} when an input is accepted and the output register is occupied and not transferring.
  - ready_o = !skid_valid. It drops in the cycle after a skid capture and returns the cycle after the skid entry drains.
- Ordering: the skid entry always drains to the output before any new input; strict FIFO order.
- Flush:
  - flush_i=1 clears valid_o and skid_valid at the next edge.
  - An input accepted in the same cycle as flush_i is dropped.
  - Flush has priority over accept and transfer.
- Reset has priority over flush.
- Immediate and field decode, by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): imm = sext(insn[31:20]).
  - S-type (0100011): imm = sext({insn[31:25], insn[11:7]}).
  - B-type (1100011): imm = sext({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}).
  - U-type (0110111, 0010111): imm = {insn[31:12], 12'b0}.
  - J-type (1101111): imm = sext({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}).
  - R-type (0110011): imm = 0.
  - Any other opcode: illegal_o=1, imm=0. Illegal instructions still flow through the stage with valid_o=1.
- Field extraction (rd/rs1/rs2/funct3/funct7) is unconditional, regardless of format.
- Simultaneous input accept and output transfer with the skid empty: the new bundle replaces the old one in the output register; no bubble.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams (OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, OP);
  - imm_fmt_e enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X};
  - decoded_t struct bundling the output fields.
- One combinational sub-module, imm_gen: insn in → imm, fmt and illegal out.
- decode_stage itself contains the skid buffer, output register and handshake logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid_i=1 → valid_o=0, all outputs 0, ready_o=1; release → first accept appears the next cycle.
- Streaming, ready_i=1: feed pc 0x0/0x4/0x8 with insns 0x00500093, 0xFE20AE23, 0xFE000CE3 → one per cycle, latency 1, no bubbles:
  - 0x00500093: rd=1, imm=5, opcode=0x13.
  - 0xFE20AE23: rs1=1, rs2=2, imm=0xFFFFFFFC.
  - 0xFE000CE3: imm=0xFFFFFFF8.
- U-type and illegal: insn 0x123452B7 → rd=5, imm=0x12345000, illegal_o=0; insn 0x0000007F → illegal_o=1, imm=0, valid_o=1.
- Backpressure: ready_i=0 for 4 cycles while valid_i=1 →
  - exactly 2 instructions are held;
  - ready_o=0 from the 2nd stall cycle onward;
  - output fields stay stable;
  - after ready_i=1, both drain in order with no loss or duplication.
- Flush with skid full: assert flush_i=1 with valid_i=1 → next cycle valid_o=0, ready_o=1; the same-cycle input is never output.
- Reset mid-operation: rst=0 while both entries are held → next cycle valid_o=0, ready_o=1; the held instructions never appear.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the decoded bundle.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational opcode classification and immediate generation for RV32I.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [ILEN-1:0] insn_i,
    output logic [XLEN-1:0] imm_c,
    output imm_fmt_e        fmt_c,
    output logic            illegal_c
);

    // Classify the opcode into an immediate format; unknown opcodes are illegal.
    always_comb begin
        fmt_c = FMT_X;
        unique case (insn_i[6:0])
            OP_IMM, LOAD, JALR, SYSTEM: fmt_c = FMT_I;
            STORE:                      fmt_c = FMT_S;
            BRANCH:                     fmt_c = FMT_B;
            LUI, AUIPC:                 fmt_c = FMT_U;
            JAL:                        fmt_c = FMT_J;
            OP:                         fmt_c = FMT_R;
            default:                    fmt_c = FMT_X;
        endcase
        illegal_c = (fmt_c == FMT_X);
    end

    // Assemble and sign-extend the immediate for the selected format.
    always_comb begin
        imm_c = '0;
        unique case (fmt_c)
            FMT_I:   imm_c = {{20{insn_i[31]}}, insn_i[31:20]};
            FMT_S:   imm_c = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            FMT_B:   imm_c = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                              insn_i[11:8], 1'b0};
            FMT_U:   imm_c = {insn_i[31:12], 12'b0};
            FMT_J:   imm_c = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                              insn_i[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: registered output slot behind a one-entry skid buffer.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    logic              out_valid_q, out_valid_d;
    decoded_t          out_q, out_d;
    logic              skid_valid_q, skid_valid_d;
    logic [AWIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DWIDTH-1:0] skid_insn_q, skid_insn_d;

    logic              accept_c;
    logic              xfer_c;
    logic              out_load_c;
    logic [AWIDTH-1:0] src_pc_c;
    logic [DWIDTH-1:0] src_insn_c;
    logic [XLEN-1:0]   imm_c;
    imm_fmt_e          fmt_c;
    logic              illegal_c;
    decoded_t          dec_c;

    assign ready_o    = !skid_valid_q;
    assign accept_c   = valid_i && ready_o;
    assign xfer_c     = out_valid_q && ready_i;
    assign out_load_c = !out_valid_q || xfer_c;

    // The held skid entry always takes precedence over the live input to keep order.
    always_comb begin
        src_pc_c   = pc_i;
        src_insn_c = insn_i;
        if (skid_valid_q) begin
            src_pc_c   = skid_pc_q;
            src_insn_c = skid_insn_q;
        end
    end

    imm_gen u_imm_gen (
        .insn_i    (ILEN'(src_insn_c)),
        .imm_c     (imm_c),
        .fmt_c     (fmt_c),
        .illegal_c (illegal_c)
    );

    // Field extraction is format-independent; only the immediate depends on the opcode.
    always_comb begin
        dec_c         = '0;
        dec_c.pc      = XLEN'(src_pc_c);
        dec_c.insn    = ILEN'(src_insn_c);
        dec_c.opcode  = src_insn_c[6:0];
        dec_c.rd      = src_insn_c[11:7];
        dec_c.funct3  = src_insn_c[14:12];
        dec_c.rs1     = src_insn_c[19:15];
        dec_c.rs2     = src_insn_c[24:20];
        dec_c.funct7  = src_insn_c[31:25];
        dec_c.imm     = imm_c;
        dec_c.illegal = illegal_c;
    end

    // Next state of output slot and skid entry; flush overrides accept and transfer.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_insn_d  = skid_insn_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load_c) begin
            if (skid_valid_q) begin
                out_d        = dec_c;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_i;
            skid_insn_d  = insn_i;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_insn_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_insn_q  <= skid_insn_d;
        end
    end

    // Format classification and the illegal flag must always agree.
    a_fmt_consistent: assert property (@(posedge clk) illegal_c == (fmt_c == FMT_X));

    assign valid_o   = out_valid_q;
    assign pc_o      = AWIDTH'(out_q.pc);
    assign insn_o    = DWIDTH'(out_q.insn);
    assign opcode_o  = out_q.opcode;
    assign rd_o      = out_q.rd;
    assign rs1_o     = out_q.rs1;
    assign rs2_o     = out_q.rs2;
    assign funct3_o  = out_q.funct3;
    assign funct7_o  = out_q.funct7;
    assign imm_o     = DWIDTH'(out_q.imm);
    assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage plus handshake corner sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] insn_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .pc_i      (pc_i),
        .insn_i    (insn_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pc_o      (pc_o),
        .insn_o    (insn_o),
        .opcode_o  (opcode_o),
        .rd_o      (rd_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .funct3_o  (funct3_o),
        .funct7_o  (funct7_o),
        .imm_o     (imm_o),
        .illegal_o (illegal_o)
    );

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } obs_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic vec_t mkv(logic [31:0] pc, logic [31:0] insn, logic [6:0] op,
                                 logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                                 logic ill);
        vec_t v;
        v.pc = pc; v.insn = insn; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    function automatic obs_t exp_of(vec_t v, logic rdy);
        obs_t o;
        o.valid = 1'b1; o.ready = rdy; o.pc = v.pc; o.insn = v.insn; o.op = v.op;
        o.rd = v.rd; o.rs1 = v.rs1; o.rs2 = v.rs2; o.f3 = v.f3; o.f7 = v.f7;
        o.imm = v.imm; o.ill = v.ill;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.valid = valid_o; o.ready = ready_o; o.pc = pc_o; o.insn = insn_o; o.op = opcode_o;
        o.rd = rd_o; o.rs1 = rs1_o; o.rs2 = rs2_o; o.f3 = funct3_o; o.f7 = funct7_o;
        o.imm = imm_o; o.ill = illegal_o;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_vr(input string name, input logic exp_valid, input logic exp_ready);
        n_vec++;
        if (valid_o !== exp_valid || ready_o !== exp_ready) begin
            n_err++;
            $display("FAIL %s got valid=%b ready=%b exp valid=%b ready=%b",
                     name, valid_o, ready_o, exp_valid, exp_ready);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input vec_t x);
        valid_i = v;
        pc_i    = x.pc;
        insn_i  = x.insn;
    endtask

    initial begin
        obs_t zero_obs;
        vec_t idle;

        //              pc     insn          op     rd     rs1    rs2    f3    f7     imm           ill
        vecs[0] = mkv(32'h0,  32'h00500093, 7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 1'b0);
        vecs[1] = mkv(32'h4,  32'hFE20AE23, 7'h23, 5'h1C, 5'd1,  5'd2,  3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0);
        vecs[2] = mkv(32'h8,  32'hFE000CE3, 7'h63, 5'h19, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFF8, 1'b0);
        vecs[3] = mkv(32'hC,  32'h123452B7, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0);
        vecs[4] = mkv(32'h10, 32'h0000007F, 7'h7F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1);
        vecs[5] = mkv(32'h14, 32'h008000EF, 7'h6F, 5'd1,  5'd0,  5'd8,  3'd0, 7'h00, 32'h00000008, 1'b0);
        vecs[6] = mkv(32'h18, 32'hFFF00013, 7'h13, 5'd0,  5'd0,  5'h1F, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0);
        vecs[7] = mkv(32'h1C, 32'h002081B3, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000, 1'b0);
        vecs[8] = mkv(32'h20, 32'hFFFFF517, 7'h17, 5'd10, 5'h1F, 5'h1F, 3'd7, 7'h7F, 32'hFFFFF000, 1'b0);
        vecs[9] = mkv(32'h24, 32'h0041A283, 7'h03, 5'd5,  5'd3,  5'd4,  3'd2, 7'h00, 32'h00000004, 1'b0);

        idle = mkv(32'hDEAD_BEE0, 32'h0000_0000, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, 1'b0);
        zero_obs = '0;
        zero_obs.ready = 1'b1;

        // Reset held with valid_i asserted: nothing may be accepted.
        rst = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        drive(1'b1, vecs[0]);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_obs($sformatf("reset_%0d", i), zero_obs);
        end

        // Release reset and stream the whole table, one per cycle, latency one.
        rst = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i]);
            cyc();
            check_obs($sformatf("stream_%0d", i), exp_of(vecs[i], 1'b1));
        end
        drive(1'b0, idle);
        cyc();
        check_vr("stream_drain", 1'b0, 1'b1);

        // Backpressure: A in the output slot, B captured by skid, C waits upstream.
        drive(1'b1, vecs[3]);
        cyc();
        check_obs("bp_load_a", exp_of(vecs[3], 1'b1));
        ready_i = 1'b0;
        drive(1'b1, vecs[4]);
        cyc();
        check_obs("bp_stall_0", exp_of(vecs[3], 1'b0));
        drive(1'b1, vecs[5]);
        for (int i = 1; i < 4; i++) begin
            cyc();
            check_obs($sformatf("bp_stall_%0d", i), exp_of(vecs[3], 1'b0));
        end
        ready_i = 1'b1;
        cyc();
        check_obs("bp_drain_b", exp_of(vecs[4], 1'b1));
        cyc();
        check_obs("bp_accept_c", exp_of(vecs[5], 1'b1));
        drive(1'b0, idle);
        cyc();
        check_vr("bp_empty", 1'b0, 1'b1);

        // Flush with the skid full: held entries and the same-cycle input vanish.
        drive(1'b1, vecs[0]);
        cyc();
        ready_i = 1'b0;
        drive(1'b1, vecs[1]);
        cyc();
        check_obs("fl_full", exp_of(vecs[0], 1'b0));
        flush_i = 1'b1;
        drive(1'b1, vecs[2]);
        cyc();
        check_vr("fl_after", 1'b0, 1'b1);
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, idle);
        cyc();
        check_vr("fl_quiet_0", 1'b0, 1'b1);
        cyc();
        check_vr("fl_quiet_1", 1'b0, 1'b1);

        // Flush while an input is accepted into an empty skid: that input is dropped.
        drive(1'b1, vecs[6]);
        cyc();
        check_obs("fl2_load", exp_of(vecs[6], 1'b1));
        flush_i = 1'b1;
        drive(1'b1, vecs[7]);
        cyc();
        check_vr("fl2_after", 1'b0, 1'b1);
        flush_i = 1'b0;
        drive(1'b0, idle);
        cyc();
        check_vr("fl2_quiet", 1'b0, 1'b1);

        // Reset mid-operation with both entries held.
        ready_i = 1'b0;
        drive(1'b1, vecs[8]);
        cyc();
        drive(1'b1, vecs[9]);
        cyc();
        check_obs("rst_mid_full", exp_of(vecs[8], 1'b0));
        rst = 1'b0;
        drive(1'b0, idle);
        cyc();
        check_obs("rst_mid", zero_obs);
        rst = 1'b1;
        ready_i = 1'b1;
        cyc();
        check_vr("rst_mid_quiet_0", 1'b0, 1'b1);
        cyc();
        check_vr("rst_mid_quiet_1", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
